keylock_ctrl: RTL
=================

# keylock_ctrl

Parametrised keypad code-lock controller: consumes debounced key events, collects digits, checks them against a master code and `NUM_SLOTS` rewritable user codes, and drives unlock, lockout and programming status. It replaces the fixed six-digit, single-user-code lock flow with configurable code length and user slots, master-gated slot programming with confirmation, failed-attempt lockout, and timed auto-relock. It sits between the keypad scanner (`enterDigit`) and the LED/pattern drivers.

## Interface

**Parameters**
- `DIGITS`, default 6: code length in digits.
- `NUM_SLOTS`, default 2: number of user code slots, range 1..10.
- `MASTER_CODE`, default `24'h555116`: BCD master code, `DIGITS*4` bits, first digit in the MSBs.
- `DEFAULT_UC`, default `24'h666666`: reset value of every user slot.
- `MAX_FAIL`, default 3: consecutive failed unlock attempts that trigger lockout.
- `LOCKOUT_CYC`, default 36_000_000: lockout duration in `hwclk` cycles (3 s at 12 MHz).
- `UNLOCK_CYC`, default 60_000_000: auto-relock delay in cycles.

**Ports**
- `hwclk` in, 1: the single clock. Synchronous, active-low reset, `resetN`.
- `resetN` in, 1: synchronous, active-low.
- `key` in, 4: key code. 0–9 are digits, 10 is `*` (clear/cancel), 11 is `#` (enter).
- `key_stb` in, 1: one-cycle strobe; `key` is valid when this is high.
- `unlocked` out, 1: lock open.
- `lockout` out, 1: lockout active.
- `prog_mode` out, 1: in any programming state.
- `err_pulse` out, 1: one-cycle pulse on any rejected action.
- `ok_pulse` out, 1: one-cycle pulse on a successful unlock or slot write.
- `state` out, 3: current FSM state encoding.
- `digit_cnt` out, `$clog2(DIGITS+1)`: number of digits buffered.

## Operation

- **Reset:**
  - State goes to LOCKED.
  - All outputs are 0.
  - Every slot loads `DEFAULT_UC`.
  - Fail counter, buffer and timers clear.
- **Digit buffer:**
  - Each digit shifts in from the LSB side.
  - `digit_cnt` saturates at `DIGITS`.
  - A digit arriving when the count is already `DIGITS` sets `ovf`.
  - `*` clears the buffer, `ovf` and the count.
  - Every `#` clears the buffer after it is evaluated.
- **Valid entry:** `digit_cnt==DIGITS` and `!ovf`.
- **Ignored keys:** codes 12–15 are ignored in all states.

**States**
- **LOCKED (0)**, on `#`:
  - Valid entry equal to `MASTER_CODE`: go to PROG_SLOT. Master wins if it also equals a user slot.
  - Valid entry equal to any slot: go to UNLOCKED, pulse `ok_pulse`, clear fail counter.
  - Otherwise: pulse `err_pulse` and increment fail counter. When the counter reaches `MAX_FAIL`, go to LOCKOUT.
- **UNLOCKED (1):**
  - `unlocked` is 1.
  - Timer counts `UNLOCK_CYC` cycles, then returns to LOCKED.
  - `#` relocks immediately.
  - Digits and `*` are ignored.
- **PROG_SLOT (2):**
  - Digit d < `NUM_SLOTS`: latch `slot=d`, go to PROG_NEW.
  - Digit ≥ `NUM_SLOTS` or `#`: pulse `err_pulse`, go to LOCKED.
  - `*`: go to LOCKED silently.
- **PROG_NEW (3):**
  - `#` with a valid entry: latch `cand`, go to PROG_CONFIRM.
  - `#` without a valid entry: pulse `err_pulse`, go to LOCKED.
  - `*`: cancel to LOCKED.
- **PROG_CONFIRM (4):**
  - `#` with a valid entry equal to `cand`: write `cand` to `slot`, pulse `ok_pulse`, go to LOCKED.
  - Else: pulse `err_pulse`, go to LOCKED; slot is unchanged.
  - `*`: cancel.
- **LOCKOUT (5):**
  - `lockout` is 1 and all keys are dropped.
  - After `LOCKOUT_CYC` cycles: go to LOCKED and clear the fail counter.
- **Fail counter scope:** programming errors do not touch it.
- **Reset mid-operation:** a pending candidate is discarded and programmed slots revert to `DEFAULT_UC`.

## Timing

- **Registered response:** `key_stb` is sampled on the `hwclk` edge. State, buffer and pulses update on that edge, so outputs are visible 1 cycle after the strobe cycle.
- **Pulses:** `err_pulse` and `ok_pulse` are exactly 1 cycle; they are never both high.
- **Back-to-back strobes:** strobes on consecutive cycles are each processed.
- **Timers:**
  - Timers load on state entry and count down one per cycle.
  - The exit transition happens in the cycle after the count reaches 0, giving N+1 cycles in the state.
  - A key in the same cycle as UNLOCKED expiry: expiry wins and the key is dropped.
- **Slot write:** the write is visible to a LOCKED comparison starting the cycle after `ok_pulse`.

## Structure

- **Package `keylock_pkg`:**
  - State enum: LOCKED=0, UNLOCKED=1, PROG_SLOT=2, PROG_NEW=3, PROG_CONFIRM=4, LOCKOUT=5.
  - Constants `KEY_STAR=10` and `KEY_HASH=11`.
- **Sub-module `digit_buffer`:** shift register, count, overflow and clear, parametrised by `DIGITS`.
- **Comparators:** slot comparison uses one parallel comparator per slot, OR-reduced.

## Test plan

Bench parameters: `UNLOCK_CYC=20`, `LOCKOUT_CYC=30`.

1. **Unlock and relock:** keys 6,6,6,6,6,6,`#` → `ok_pulse` 1 cycle later, `unlocked=1`. `unlocked` holds for 21 cycles, then returns to LOCKED.
2. **Lockout:** keys 1,2,3,4,5,6,`#` three times → three `err_pulse`, then `lockout=1`. Keys during lockout are ignored. After 31 cycles the state is LOCKED, and 666666`#` unlocks.
3. **Slot programming:** keys 555116`#`, 1, 123456`#`, 123456`#` → `ok_pulse`. 123456`#` then unlocks, and 666666`#` still unlocks via slot 0.
4. **Confirm mismatch:** 555116`#`, 0, 111111`#`, 111112`#` → `err_pulse`. 666666`#` still unlocks; fail counter still 0.
5. **Buffer boundaries:**
   - 7 digits then `#` → `err_pulse` (overflow).
   - 66`*`666666`#` → unlock.
   - 5 digits `#` → err.
   - Slot digit 2 with `NUM_SLOTS=2` → err.
6. **Reset mid-operation:** assert `resetN=0` for 1 cycle in PROG_CONFIRM → `state=0`, all outputs 0, slots equal `DEFAULT_UC`.

Source files
------------

// File: rtl/keylock_pkg.sv
// rtl/keylock_pkg.sv - shared state encoding and key codes for the keypad lock
package keylock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED       = 3'd0,
    ST_UNLOCKED     = 3'd1,
    ST_PROG_SLOT    = 3'd2,
    ST_PROG_NEW     = 3'd3,
    ST_PROG_CONFIRM = 3'd4,
    ST_LOCKOUT      = 3'd5
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic is_digit_key(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keylock_ctrl_digit_buffer.sv
// rtl/keylock_ctrl_digit_buffer.sv - BCD entry shift register with saturating count and overflow
module digit_buffer #(
  parameter int DIGITS = 6,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                  hwclk,
  input  logic                  resetN,
  input  logic                  shift,
  input  logic [3:0]            digit,
  input  logic                  clr,
  output logic [DIGITS*4-1:0]   code,
  output logic [CW-1:0]         cnt,
  output logic                  ovf
);

  logic [DIGITS*4-1:0] code_q, code_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      code_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (shift) begin
      code_d = {code_q[DIGITS*4-5:0], digit};
      // An extra digit poisons the entry rather than silently dropping the oldest.
      if (cnt_q == CW'(DIGITS)) ovf_d = 1'b1;
      else                      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hwclk) begin
    if (!resetN) begin
      code_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign code = code_q;
  assign cnt  = cnt_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/keylock_ctrl.sv
// rtl/keylock_ctrl.sv - keypad code lock: master/user codes, slot programming, lockout, auto-relock
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int                 DIGITS      = 6,
  parameter int                 NUM_SLOTS   = 2,
  parameter logic [DIGITS*4-1:0] MASTER_CODE = 24'h555116,
  parameter logic [DIGITS*4-1:0] DEFAULT_UC  = 24'h666666,
  parameter int                 MAX_FAIL    = 3,
  parameter int                 LOCKOUT_CYC = 36_000_000,
  parameter int                 UNLOCK_CYC  = 60_000_000
) (
  input  logic                         hwclk,
  input  logic                         resetN,
  input  logic [3:0]                   key,
  input  logic                         key_stb,
  output logic                         unlocked,
  output logic                         lockout,
  output logic                         prog_mode,
  output logic                         err_pulse,
  output logic                         ok_pulse,
  output logic [2:0]                   state,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

  localparam int CW   = $clog2(DIGITS + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD   = DIGITS * 4;

  state_t          state_q, state_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CD-1:0]   cand_q, cand_d;
  logic [CD-1:0]   codes_q [NUM_SLOTS];
  logic [CD-1:0]   codes_d [NUM_SLOTS];
  logic            err_q, err_d;
  logic            ok_q, ok_d;

  logic            key_ok, is_dig, is_star, is_hash;
  logic            shift_en, clr_en;
  logic [CD-1:0]   entry;
  logic [CW-1:0]   entry_cnt;
  logic            entry_ovf, entry_valid;
  logic [NUM_SLOTS-1:0] slot_match;
  logic            slot_hit;

  assign key_ok  = key_stb && (key <= KEY_HASH);
  assign is_dig  = key_ok && is_digit_key(key);
  assign is_star = key_ok && (key == KEY_STAR);
  assign is_hash = key_ok && (key == KEY_HASH);

  // Digits only accumulate where a code is being typed; UNLOCKED and PROG_SLOT consume them otherwise.
  assign shift_en = is_dig && (state_q == ST_LOCKED || state_q == ST_PROG_NEW ||
                               state_q == ST_PROG_CONFIRM);
  assign clr_en   = (is_star || is_hash) && (state_q != ST_LOCKOUT);

  digit_buffer #(.DIGITS(DIGITS)) u_buf (
    .hwclk  (hwclk),
    .resetN (resetN),
    .shift  (shift_en),
    .digit  (key),
    .clr    (clr_en),
    .code   (entry),
    .cnt    (entry_cnt),
    .ovf    (entry_ovf)
  );

  assign entry_valid = (entry_cnt == CW'(DIGITS)) && !entry_ovf;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) slot_match[i] = (codes_q[i] == entry);
  end
  assign slot_hit = |slot_match;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    slot_d  = slot_q;
    cand_d  = cand_q;
    codes_d = codes_q;
    err_d   = 1'b0;
    ok_d    = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (is_hash) begin
          if (entry_valid && entry == MASTER_CODE) begin
            state_d = ST_PROG_SLOT;
          end else if (entry_valid && slot_hit) begin
            state_d = ST_UNLOCKED;
            timer_d = TW'(UNLOCK_CYC);
            fail_d  = '0;
            ok_d    = 1'b1;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 1'b1;
            if (fail_q == FW'(MAX_FAIL - 1)) begin
              state_d = ST_LOCKOUT;
              timer_d = TW'(LOCKOUT_CYC);
            end
          end
        end
      end
      ST_UNLOCKED: begin
        // Expiry takes priority over a coincident key.
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - 1'b1;
          if (is_hash) state_d = ST_LOCKED;
        end
      end
      ST_PROG_SLOT: begin
        if (is_dig) begin
          if (int'(key) < NUM_SLOTS) begin
            slot_d  = key[SW-1:0];
            state_d = ST_PROG_NEW;
          end else begin
            err_d   = 1'b1;
            state_d = ST_LOCKED;
          end
        end else if (is_hash) begin
          err_d   = 1'b1;
          state_d = ST_LOCKED;
        end else if (is_star) begin
          state_d = ST_LOCKED;
        end
      end
      ST_PROG_NEW: begin
        if (is_hash) begin
          if (entry_valid) begin
            cand_d  = entry;
            state_d = ST_PROG_CONFIRM;
          end else begin
            err_d   = 1'b1;
            state_d = ST_LOCKED;
          end
        end else if (is_star) begin
          state_d = ST_LOCKED;
        end
      end
      ST_PROG_CONFIRM: begin
        if (is_hash) begin
          if (entry_valid && entry == cand_q) begin
            for (int i = 0; i < NUM_SLOTS; i++)
              if (slot_q == SW'(i)) codes_d[i] = cand_q;
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_LOCKED;
        end else if (is_star) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!resetN) begin
      state_q <= ST_LOCKED;
      fail_q  <= '0;
      timer_q <= '0;
      slot_q  <= '0;
      cand_q  <= '0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) codes_q[i] <= DEFAULT_UC;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      slot_q  <= slot_d;
      cand_q  <= cand_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      for (int i = 0; i < NUM_SLOTS; i++) codes_q[i] <= codes_d[i];
    end
  end

  assign unlocked  = (state_q == ST_UNLOCKED);
  assign lockout   = (state_q == ST_LOCKOUT);
  assign prog_mode = (state_q == ST_PROG_SLOT) || (state_q == ST_PROG_NEW) ||
                     (state_q == ST_PROG_CONFIRM);
  assign err_pulse = err_q;
  assign ok_pulse  = ok_q;
  assign state     = state_q;
  assign digit_cnt = entry_cnt;

endmodule
